// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the single register-file write port,
// plus the per-register busy scoreboard used by issue for hazard stalls.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [5*NREQ-1:0]    req_rd,
  input  logic [XLEN*NREQ-1:0] req_data,
  input  logic                 iss_valid,
  input  logic [4:0]           iss_rd,
  output logic                 w_en,
  output logic [4:0]           w_reg,
  output logic [XLEN-1:0]      w_data,
  output logic [31:0]          busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   cand;
  logic            found;
  logic            xfer;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [PW-1:0]   rr_next;
  logic [31:0]     busy_next;
  int              idx;

  // Priority search starting at rr_ptr; depends only on req_valid and rr_ptr.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = PW'(idx);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = !rst && found && (grant_idx == PW'(i));
    end
  end

  assign xfer     = |req_ready;
  assign sel_rd   = req_rd[int'(grant_idx)*5 +: 5];
  assign sel_data = req_data[int'(grant_idx)*XLEN +: XLEN];
  assign rr_next  = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + PW'(1);

  // Set is applied after clear so a same-register collision leaves the bit set.
  always_comb begin
    busy_next = busy;
    if (w_en) busy_next[w_reg] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0)) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      w_en   <= 1'b0;
      w_reg  <= '0;
      w_data <= '0;
      busy   <= '0;
    end else begin
      busy <= busy_next;
      if (xfer) begin
        rr_ptr <= rr_next;
        w_en   <= (sel_rd != 5'd0);
        w_reg  <= sel_rd;
        w_data <= sel_data;
      end else begin
        w_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed plan scenarios followed by
// randomized traffic, checked against a cycle-level behavioural model.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [5*NREQ-1:0]    req_rd;
  logic [XLEN*NREQ-1:0] req_data;
  logic                 iss_valid;
  logic [4:0]           iss_rd;
  logic                 w_en;
  logic [4:0]           w_reg;
  logic [XLEN-1:0]      w_data;
  logic [31:0]          busy;

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .w_en(w_en), .w_reg(w_reg), .w_data(w_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] ready;
    logic            wen;
    logic [4:0]      wreg;
    logic [XLEN-1:0] wdata;
    logic [31:0]     bsy;
  } cyc_t;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  cyc_t cq[$];
  wr_t  wq[$];

  int tests = 0;
  int fails = 0;

  // Stimulus-side state: requesters hold their request until granted.
  logic            rv[NREQ];
  logic [4:0]      rrd[NREQ];
  logic [XLEN-1:0] rdat[NREQ];
  logic            t_rst;
  logic            t_iss;
  logic [4:0]      t_iss_rd;

  // Reference model state.
  int              m_rr;
  logic            m_wen;
  logic [4:0]      m_wreg;
  logic [XLEN-1:0] m_wdata;
  logic [31:0]     m_busy;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    int   g;
    cyc_t rec;
    wr_t  w;
    @(posedge clk);
    #1;
    rst       = t_rst;
    iss_valid = t_iss;
    iss_rd    = t_iss_rd;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = rv[i];
      req_rd[5*i +: 5]       = rrd[i];
      req_data[XLEN*i +: XLEN] = rdat[i];
    end
    g = -1;
    if (!t_rst) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && rv[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
      end
    end
    rec.ready = '0;
    if (g >= 0) rec.ready[g] = 1'b1;
    rec.wen   = m_wen;
    rec.wreg  = m_wreg;
    rec.wdata = m_wdata;
    rec.bsy   = m_busy;
    cq.push_back(rec);
    if (t_rst) begin
      m_rr = 0; m_wen = 0; m_wreg = '0; m_wdata = '0; m_busy = '0;
      for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;
    end else begin
      if (m_wen) m_busy[m_wreg] = 1'b0;
      if (t_iss && t_iss_rd != 0) m_busy[t_iss_rd] = 1'b1;
      if (g >= 0) begin
        m_rr    = (g + 1) % NREQ;
        m_wen   = (rrd[g] != 0);
        m_wreg  = rrd[g];
        m_wdata = rdat[g];
        if (rrd[g] != 0) begin
          w.rd = rrd[g]; w.data = rdat[g];
          wq.push_back(w);
        end
        rv[g] = 1'b0;
      end else begin
        m_wen = 1'b0;
      end
    end
    t_iss = 1'b0;
  endtask

  // Monitor: per-cycle expectations plus an event-driven write-port check.
  always @(negedge clk) begin
    cyc_t c;
    wr_t  w;
    if (cq.size() > 0) begin
      c = cq.pop_front();
      chk("req_ready", XLEN'(req_ready), XLEN'(c.ready));
      chk("w_en", XLEN'(w_en), XLEN'(c.wen));
      chk("w_reg", XLEN'(w_reg), XLEN'(c.wreg));
      chk("w_data", w_data, c.wdata);
      chk("busy", XLEN'(busy), XLEN'(c.bsy));
    end
    if (w_en === 1'b1) begin
      if (wq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write: got reg %0d data %0h, expected no write", w_reg, w_data);
      end else begin
        w = wq.pop_front();
        chk("wr_reg", XLEN'(w_reg), XLEN'(w.rd));
        chk("wr_data", w_data, w.data);
      end
    end
  end

  task automatic set_req(input int i, input logic [4:0] rd, input logic [XLEN-1:0] d);
    rv[i] = 1'b1; rrd[i] = rd; rdat[i] = d;
  endtask

  task automatic issue(input logic [4:0] rd);
    t_iss = 1'b1; t_iss_rd = rd;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin rv[i] = 0; rrd[i] = 0; rdat[i] = 0; end
    t_rst = 1'b1; t_iss = 1'b0; t_iss_rd = '0;
    m_rr = 0; m_wen = 0; m_wreg = '0; m_wdata = '0; m_busy = '0;
    rst = 1'b1; req_valid = '0; req_rd = '0; req_data = '0; iss_valid = 1'b0; iss_rd = '0;
    repeat (2) @(posedge clk);

    // Reset held with everything asserted.
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), XLEN'(i + 64'hA));
      issue(5'd5);
      cycle();
    end
    t_rst = 1'b0;

    // Round-robin with all three continuously valid.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), XLEN'(i + 64'hA));
      cycle();
    end
    for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;
    cycle(); cycle();

    // Single request from MDU, then x0 write from LSU.
    set_req(2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF); cycle(); cycle();
    set_req(1, 5'd0, 64'h1234); cycle(); cycle();

    // Scoreboard life cycle on x9.
    issue(5'd9); cycle();
    cycle(); cycle();
    set_req(0, 5'd9, 64'h99); cycle();
    cycle(); cycle(); cycle();

    // Same-edge set/clear: same register, then different registers.
    issue(5'd4); cycle();
    set_req(0, 5'd4, 64'h44); cycle();
    issue(5'd4); cycle();
    cycle();
    set_req(1, 5'd4, 64'h45); cycle();
    issue(5'd6); cycle();
    cycle();

    // Reset mid-operation with busy bits pending and a request outstanding.
    for (int r = 8; r < 12; r++) begin issue(5'(r)); cycle(); end
    cycle();
    set_req(1, 5'd3, 64'h33);
    t_rst = 1'b1; cycle();
    t_rst = 1'b0; cycle();
    set_req(0, 5'd2, 64'h22); set_req(2, 5'd3, 64'h23); cycle(); cycle(); cycle();

    // Randomized traffic with legal issue (never to a busy register).
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rv[i] && ($urandom % 3 == 0))
          set_req(i, 5'($urandom_range(0, 31)), {$urandom, $urandom});
      end
      if ($urandom % 2 == 0) begin
        logic [4:0] r;
        r = 5'($urandom_range(0, 31));
        if (!m_busy[r]) issue(r);
      end
      t_rst = ($urandom % 150 == 0);
      cycle();
      t_rst = 1'b0;
    end
    repeat (8) cycle();
    @(negedge clk); #1;
    chk("cycle_queue_drained", XLEN'(cq.size()), XLEN'(0));
    chk("write_queue_drained", XLEN'(wq.size()), XLEN'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
